// File: rtl/wb_stage.sv
// Write-back stage: load extraction, register-file retire, exception CSR file,
// and syscall/ertn flush/redirect generation for the five-stage pipeline.
module wb_stage #(
  parameter logic [31:0] CRMD_RESET = 32'h0000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        to_ws_valid,
  output logic        ws_allow_in,
  output logic        ws_valid,
  input  logic [31:0] ws_pc,
  input  logic [3:0]  ws_rf_we,
  input  logic [4:0]  ws_rf_waddr,
  input  logic [31:0] ws_rf_wdata,
  input  logic [3:0]  ws_mem_op,
  input  logic [31:0] ws_sram_addr,
  input  logic [31:0] data_sram_rdata,
  input  logic        ws_csr_rd,
  input  logic [3:0]  ws_csr_we,
  input  logic [13:0] ws_csr_num,
  input  logic [31:0] ws_csr_wdata,
  input  logic [31:0] ws_csr_wmask,
  input  logic        ws_ertn,
  input  logic        ws_syscall,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        flush,
  output logic [31:0] flush_target,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_we,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_EENTRY = 14'h00C;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_SAVE1  = 14'h031;
  localparam logic [13:0] CSR_SAVE2  = 14'h032;
  localparam logic [13:0] CSR_SAVE3  = 14'h033;

  localparam logic [31:0] CRMD_WM   = 32'h0000_000F;
  localparam logic [31:0] PRMD_WM   = 32'h0000_0007;
  localparam logic [31:0] ESTAT_WM  = 32'h7FFF_0000;
  localparam logic [31:0] FULL_WM   = 32'hFFFF_FFFF;
  localparam logic [31:0] EENTRY_WM = 32'hFFFF_FFC0;
  localparam logic [5:0]  ECODE_SYS = 6'h0B;

  function automatic logic [31:0] csr_merge(input logic [31:0] old_v, input logic [31:0] wdata,
                                            input logic [31:0] wmask, input logic [31:0] writable);
    csr_merge = ((old_v & ~wmask) | (wdata & wmask)) & writable;
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    case (op)
      4'b0000, 4'b1000, 4'b0001, 4'b1001, 4'b0010: is_load = 1'b1;
      default: is_load = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [3:0] op, input logic [1:0] off,
                                           input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      4'b0000: load_ext = {{24{b[7]}}, b};
      4'b1000: load_ext = {24'h00_0000, b};
      4'b0001: load_ext = {{16{h[15]}}, h};
      4'b1001: load_ext = {16'h0000, h};
      default: load_ext = rdata;
    endcase
  endfunction

  logic              ws_valid_r;
  logic [31:0]       crmd_r, prmd_r, estat_r, era_r, eentry_r;
  logic [31:0]       crmd_nx, prmd_nx, estat_nx, era_nx, eentry_nx;
  logic [3:0][31:0]  save_r, save_nx;
  logic [31:0]       csr_rvalue_s;
  logic              exc_sys_s, exc_ertn_s, csr_wr_s;
  logic              unused_s;

  assign exc_sys_s  = ws_valid_r & ws_syscall;
  assign exc_ertn_s = ws_valid_r & ws_ertn & ~ws_syscall;
  assign csr_wr_s   = ws_valid_r & (|ws_csr_we) & ~ws_syscall;
  assign unused_s   = &{1'b0, ws_sram_addr[31:2]};

  // WB valid bit: a flush kills whatever MEM is handing over this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid_r <= 1'b0;
    end else if (flush) begin
      ws_valid_r <= 1'b0;
    end else begin
      ws_valid_r <= to_ws_valid;
    end
  end

  // CSR next-state: syscall overrides everything, ertn overrides a same-cycle CRMD write.
  always_comb begin
    crmd_nx   = crmd_r;
    prmd_nx   = prmd_r;
    estat_nx  = estat_r;
    era_nx    = era_r;
    eentry_nx = eentry_r;
    save_nx   = save_r;
    if (exc_sys_s) begin
      prmd_nx  = {29'h0000_0000, crmd_r[2:0]};
      crmd_nx  = {crmd_r[31:3], 3'b000};
      era_nx   = ws_pc;
      estat_nx = {1'b0, 9'h000, ECODE_SYS, 16'h0000};
    end else begin
      if (csr_wr_s) begin
        case (ws_csr_num)
          CSR_CRMD:   crmd_nx    = csr_merge(crmd_r, ws_csr_wdata, ws_csr_wmask, CRMD_WM);
          CSR_PRMD:   prmd_nx    = csr_merge(prmd_r, ws_csr_wdata, ws_csr_wmask, PRMD_WM);
          CSR_ESTAT:  estat_nx   = csr_merge(estat_r, ws_csr_wdata, ws_csr_wmask, ESTAT_WM);
          CSR_ERA:    era_nx     = csr_merge(era_r, ws_csr_wdata, ws_csr_wmask, FULL_WM);
          CSR_EENTRY: eentry_nx  = csr_merge(eentry_r, ws_csr_wdata, ws_csr_wmask, EENTRY_WM);
          CSR_SAVE0:  save_nx[0] = csr_merge(save_r[0], ws_csr_wdata, ws_csr_wmask, FULL_WM);
          CSR_SAVE1:  save_nx[1] = csr_merge(save_r[1], ws_csr_wdata, ws_csr_wmask, FULL_WM);
          CSR_SAVE2:  save_nx[2] = csr_merge(save_r[2], ws_csr_wdata, ws_csr_wmask, FULL_WM);
          CSR_SAVE3:  save_nx[3] = csr_merge(save_r[3], ws_csr_wdata, ws_csr_wmask, FULL_WM);
          default:    crmd_nx    = crmd_r;
        endcase
      end else begin
        crmd_nx = crmd_r;
      end
      crmd_nx = exc_ertn_s ? {crmd_nx[31:3], prmd_r[2:0]} : crmd_nx;
    end
  end

  // CSR state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      crmd_r   <= CRMD_RESET & CRMD_WM;
      prmd_r   <= 32'h0000_0000;
      estat_r  <= 32'h0000_0000;
      era_r    <= 32'h0000_0000;
      eentry_r <= 32'h0000_0000;
      save_r   <= '0;
    end else begin
      crmd_r   <= crmd_nx;
      prmd_r   <= prmd_nx;
      estat_r  <= estat_nx;
      era_r    <= era_nx;
      eentry_r <= eentry_nx;
      save_r   <= save_nx;
    end
  end

  // Combinational CSR read of pre-edge state (csrxchg sees the old value).
  always_comb begin
    case (ws_csr_num)
      CSR_CRMD:   csr_rvalue_s = crmd_r;
      CSR_PRMD:   csr_rvalue_s = prmd_r;
      CSR_ESTAT:  csr_rvalue_s = estat_r;
      CSR_ERA:    csr_rvalue_s = era_r;
      CSR_EENTRY: csr_rvalue_s = eentry_r;
      CSR_SAVE0:  csr_rvalue_s = save_r[0];
      CSR_SAVE1:  csr_rvalue_s = save_r[1];
      CSR_SAVE2:  csr_rvalue_s = save_r[2];
      CSR_SAVE3:  csr_rvalue_s = save_r[3];
      default:    csr_rvalue_s = 32'h0000_0000;
    endcase
  end

  assign ws_allow_in  = 1'b1;
  assign ws_valid     = ws_valid_r;
  assign rf_we        = ws_valid_r & (|ws_rf_we) & ~ws_syscall;
  assign rf_waddr     = ws_rf_waddr;
  assign rf_wdata     = ws_csr_rd ? csr_rvalue_s :
                        is_load(ws_mem_op) ? load_ext(ws_mem_op, ws_sram_addr[1:0], data_sram_rdata) :
                        ws_rf_wdata;
  assign flush        = exc_sys_s | exc_ertn_s;
  assign flush_target = exc_sys_s ? eentry_r : (exc_ertn_s ? era_r : 32'h0000_0000);

  assign debug_wb_pc       = ws_pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the five-stage pipeline, sitting directly downstream of the MEM→WB pipeline register. It holds the WB valid bit, extracts and extends load data returned by the synchronous data SRAM, retires register-file writes, and owns the exception CSR file. It raises the pipeline-wide flush and redirect target for `syscall` and `ertn`, and drives the debug trace port.

## Interface
Parameters:
- `CRMD_RESET`, default 32'h0000_0008: CRMD value after reset (DA=1, PLV=0, IE=0).

Ports (clock and reset first):
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `to_ws_valid` in 1: MEM holds a valid instruction and its `ms_ready_go` is 1.
- `ws_allow_in` out 1: WB accepts a new instruction; drives MEM's `wb_allow_in`.
- `ws_valid` out 1: WB holds a valid instruction.
- `ws_pc` in 32: PC of the WB instruction.
- `ws_rf_we` in 4: register-file write enable; any bit set means write.
- `ws_rf_waddr` in 5: destination register.
- `ws_rf_wdata` in 32: ALU/EX result.
- `ws_mem_op` in 4: memory opcode.
- `ws_sram_addr` in 32: data address, used for load alignment.
- `data_sram_rdata` in 32: SRAM read data, valid in WB.
- `ws_csr_rd` in 1: destination takes the CSR read value (csrrd/csrwr/csrxchg).
- `ws_csr_we` in 4: CSR write enable; any bit set means write.
- `ws_csr_num` in 14: CSR address.
- `ws_csr_wdata` in 32: CSR write data.
- `ws_csr_wmask` in 32: CSR write mask.
- `ws_ertn` in 1: instruction is ertn.
- `ws_syscall` in 1: instruction is syscall.
- `rf_we` out 1: register-file write enable.
- `rf_waddr` out 5: register-file write address.
- `rf_wdata` out 32: register-file write data.
- `flush` out 1: flush IF/ID/EX/MEM and the WB register.
- `flush_target` out 32: redirect PC.
- `debug_wb_pc` out 32: trace PC.
- `debug_wb_rf_we` out 4: trace write enable.
- `debug_wb_rf_wnum` out 5: trace register number.
- `debug_wb_rf_wdata` out 32: trace write data.

## Operation
- **Handshake**
  - `ws_ready_go` = 1, so `ws_allow_in` = 1 always.
  - `ws_valid` <= 0 on `reset` or `flush`; otherwise `ws_valid` <= `to_ws_valid`.
- **Load extraction:** `b` = byte at `ws_sram_addr[1:0]`; `h` = halfword at `ws_sram_addr[1]` (low when 0).
  - 0000 ld.b: sign-extend `b`.
  - 1000 ld.bu: zero-extend `b`.
  - 0001 ld.h: sign-extend `h`.
  - 1001 ld.hu: zero-extend `h`.
  - 0010 ld.w: full word.
  - Any other code is not a load.
- **Write-data mux:** `rf_wdata` = `ws_csr_rd` ? `csr_rvalue` : load ? extracted data : `ws_rf_wdata`.
- **Register-file write:** `rf_we` = `ws_valid` & |`ws_rf_we` & !`ws_syscall`. `rf_waddr` = `ws_rf_waddr`.
- **CSR file**, all registers cleared by reset except CRMD:
  - CRMD 0x0: PLV[1:0], IE[2], DA[3].
  - PRMD 0x1: PPLV[1:0], PIE[2].
  - ESTAT 0x5: Ecode[21:16], EsubCode[30:22].
  - ERA 0x6: 32 bits.
  - EENTRY 0xC: bits [31:6] writable; [5:0] read 0.
  - SAVE0–3 0x30–0x33: 32 bits each.
  - Unimplemented bits and unknown numbers read 0 and ignore writes.
- **CSR read:** `csr_rvalue` is a combinational read of the pre-edge state, so csrxchg returns the old value.
- **CSR write:** when `ws_valid` & |`ws_csr_we` & !`ws_syscall`, new = (old & ~`ws_csr_wmask`) | (`ws_csr_wdata` & `ws_csr_wmask`), restricted to writable bits.
- **syscall** (`ws_valid` & `ws_syscall`):
  - PRMD.PPLV <= CRMD.PLV; PRMD.PIE <= CRMD.IE.
  - CRMD.PLV <= 0; CRMD.IE <= 0.
  - ERA <= `ws_pc`.
  - ESTAT.Ecode <= 6'h0B; ESTAT.EsubCode <= 0.
  - `flush` = 1; `flush_target` = EENTRY.
- **ertn** (`ws_valid` & `ws_ertn` & !`ws_syscall`):
  - CRMD.PLV <= PRMD.PPLV; CRMD.IE <= PRMD.PIE.
  - `flush` = 1; `flush_target` = ERA.
- **Priority:** syscall beats ertn; the exception update beats an explicit CSR write in the same cycle. `flush_target` = 0 when `flush` = 0.
- **Trace port:**
  - `debug_wb_pc` = `ws_pc`.
  - `debug_wb_rf_we` = {4{`rf_we`}}.
  - `debug_wb_rf_wnum` = `rf_waddr`.
  - `debug_wb_rf_wdata` = `rf_wdata`.

## Timing
- All outputs are combinational from the `ws_*` inputs, `ws_valid` and CSR state. CSR state and `ws_valid` update at posedge `clk`.
- Reset values:
  - `ws_valid` = 0, hence `rf_we` = 0, `flush` = 0, `flush_target` = 0 and `debug_wb_rf_we` = 0.
  - CRMD = `CRMD_RESET`; all other CSRs = 0.
- Latency:
  - An instruction accepted at edge N retires (rf/CSR write, flush) during cycle N; its CSR effects are visible after edge N+1.
  - Load data is used in the same cycle it arrives on `data_sram_rdata`.
- Flush:
  - `flush` is asserted for exactly the single cycle in which the syscall/ertn is valid in WB.
  - At the next edge `ws_valid` drops even if `to_ws_valid` = 1.
- Reset mid-operation: any pending CSR write or exception in that cycle is discarded; CSRs take reset values.
- Back-to-back: a CSR written in cycle N is read correctly by an instruction in WB in cycle N+1.

## Test plan
- Reset, then idle for 3 cycles → `rf_we` = 0, `flush` = 0, CRMD reads 0x8, `ws_valid` = 0.
- ld.b: `ws_mem_op` = 0000, `ws_sram_addr[1:0]` = 2'b11, `data_sram_rdata` = 0x80_12_34_56 → `rf_wdata` = 0xFFFFFF80. With `ws_mem_op` = 1001 and addr[1] = 1 → 0x00008012.
- csrxchg on SAVE0: SAVE0 = 0xAAAA_AAAA, `ws_csr_wdata` = 0x5555_5555, mask = 0x0000_FFFF, `ws_csr_rd` = 1 → `rf_wdata` = 0xAAAAAAAA; next cycle SAVE0 reads 0xAAAA5555.
- syscall: CRMD = 0x7 (PLV=3, IE=1), EENTRY = 0x1C00_8000, `ws_pc` = 0x1C00_0100 → `flush` = 1, `flush_target` = 0x1C008000, `rf_we` = 0. Next cycle: ERA = 0x1C000100, PRMD = 0x7, CRMD[2:0] = 0, ESTAT[21:16] = 0x0B, `ws_valid` = 0.
- ertn following that syscall → `flush` = 1, `flush_target` = 0x1C000100; next cycle CRMD[2:0] = 0x7.
- Simultaneous `ws_syscall` and `ws_csr_we` targeting ERA with data 0x1234 → ERA = `ws_pc` (exception wins); CSR write suppressed.
